// File: rtl/ama_riscv_lsu_pkg.sv
// ama_riscv_lsu_pkg
// Shared definitions for the AMA-RISCV load/store path: access-size
// encodings taken from funct3[1:0], the position of the unsigned-load flag
// inside funct3, and the state encoding of the data-memory request FSM.
package ama_riscv_lsu_pkg;

    // Access size, as carried in funct3[1:0]
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // funct3[2] marks a zero-extending load (lbu/lhu)
    localparam int FUNCT3_UNSIGNED_BIT = 2;

    // Request FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } dmem_state_e;

    // Extract the access size field from a funct3 value
    function automatic logic [1:0] funct3_size(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/ama_riscv_store_align.sv
// ama_riscv_store_align
// Purely combinational store lane alignment. Given an access size and the
// byte offset inside the 32-bit word it produces the byte-write-enable mask,
// the store data replicated onto every lane, and an illegal flag for sizes
// or offsets that cannot be expressed as a single aligned word access. The
// illegal flag is also the load misalignment check, since loads and stores
// share the same size/offset legality rules.
//
// Ports:
//   size_i    in  2   access size (SZ_B / SZ_H / SZ_W, 3 is reserved)
//   offset_i  in  2   byte address bits [1:0]
//   wdata_i   in  32  LSB-justified store data
//   be_o      out 4   byte enables (0 when illegal)
//   data_o    out 32  lane-replicated store data
//   illegal_o out 1   size/offset combination not allowed
module ama_riscv_store_align
    import ama_riscv_lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] data_o,
    output logic        illegal_o
);

    // Each byte lane picks the source byte that lands on it: the low byte
    // for byte stores, the matching half of the low halfword for half
    // stores, and the byte in place for word stores. Replicating this way
    // means the memory only needs the byte enables to select the target.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                data_o[gi*8 +: 8] = wdata_i[gi*8 +: 8];
                case (size_i)
                    SZ_B:    data_o[gi*8 +: 8] = wdata_i[7:0];
                    SZ_H:    data_o[gi*8 +: 8] = wdata_i[(gi % 2)*8 +: 8];
                    default: data_o[gi*8 +: 8] = wdata_i[gi*8 +: 8];
                endcase
            end
        end
    endgenerate

    always_comb begin
        be_o      = 4'b0000;
        illegal_o = 1'b0;
        case (size_i)
            SZ_B: begin
                be_o = 4'b0001 << offset_i;
            end
            SZ_H: begin
                // A halfword at offset 3 would straddle two words
                if (offset_i == 2'd3) begin
                    illegal_o = 1'b1;
                end else begin
                    be_o = 4'b0011 << offset_i;
                end
            end
            SZ_W: begin
                if (offset_i != 2'd0) begin
                    illegal_o = 1'b1;
                end else begin
                    be_o = 4'b1111;
                end
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ama_riscv_dmem_req.sv
// ama_riscv_dmem_req
// Data-memory request stage of the AMA-RISCV load/store path. Accepts one
// load or store per valid/ready handshake, rejects misaligned or malformed
// requests with a one-cycle misaligned pulse, and otherwise issues a single
// one-cycle dmem_en strobe with word address, byte enables and replicated
// store data. It then waits (unbounded) for dmem_ack. For loads, the ack
// cycle raises lsm_en so the downstream load_shift_mask captures dmem_dout
// together with the held offset/width.
//
// Build option:
//   DMEM_REQ_B2B_EN  when defined, a new request may be accepted in the ack
//                    cycle, giving one access every 2 cycles. Otherwise the
//                    stage returns to IDLE first (one access per 3 cycles).
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_valid/ready   request handshake
//   req_we            1 = store, 0 = load
//   req_addr          byte address
//   req_funct3        RISC-V funct3 (size in [1:0], unsigned flag in [2])
//   req_wdata         LSB-justified store data
//   dmem_en           one-cycle access strobe
//   dmem_we           byte write enables (0 for loads)
//   dmem_addr         word address req_addr[DMEM_AW+1:2]
//   dmem_din          lane-replicated store data
//   dmem_ack          memory completion (dmem_dout valid same cycle)
//   lsm_en            load result strobe for load_shift_mask
//   lsm_offset        held byte offset of the outstanding load
//   lsm_width         held funct3 of the outstanding load
//   misaligned        one-cycle pulse for a rejected request
//   stall             req_valid && !req_ready
module ama_riscv_dmem_req
    import ama_riscv_lsu_pkg::*;
#(
    parameter int DMEM_AW = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_wdata,
    output logic               dmem_en,
    output logic [3:0]         dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_din,
    input  logic               dmem_ack,
    output logic               lsm_en,
    output logic [1:0]         lsm_offset,
    output logic [2:0]         lsm_width,
    output logic               misaligned,
    output logic               stall
);

    dmem_state_e        state_q, state_d;
    logic               dmem_en_q, dmem_en_d;
    logic [3:0]         dmem_we_q, dmem_we_d;
    logic [DMEM_AW-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]        dmem_din_q, dmem_din_d;
    logic               we_q, we_d;
    logic [1:0]         offset_q, offset_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               misaligned_q, misaligned_d;

    logic [3:0]         sa_be;
    logic [31:0]        sa_data;
    logic               sa_illegal;
    logic               req_illegal;
    logic               ack_busy;
    logic               accept;

    // Upper address bits beyond the memory window are intentionally dropped
    logic               unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:DMEM_AW+2];

    ama_riscv_store_align u_store_align (
        .size_i    (funct3_size(req_funct3)),
        .offset_i  (req_addr[1:0]),
        .wdata_i   (req_wdata),
        .be_o      (sa_be),
        .data_o    (sa_data),
        .illegal_o (sa_illegal)
    );

    // Stores have no signed/unsigned variant, so funct3[2] on a store is
    // a malformed request and is rejected the same way as misalignment.
    assign req_illegal = sa_illegal || (req_we && req_funct3[FUNCT3_UNSIGNED_BIT]);

    // An ack arriving together with reset must not complete anything
    assign ack_busy = (state_q == ST_BUSY) && dmem_ack && !rst;

`ifdef DMEM_REQ_B2B_EN
    assign req_ready = (state_q == ST_IDLE) || ack_busy;
`else
    assign req_ready = (state_q == ST_IDLE);
`endif

    assign accept = req_valid && req_ready;
    assign stall  = req_valid && !req_ready;
    assign lsm_en = ack_busy && !we_q;

    always_comb begin
        state_d      = state_q;
        dmem_en_d    = 1'b0;
        dmem_we_d    = 4'b0000;
        dmem_addr_d  = dmem_addr_q;
        dmem_din_d   = dmem_din_q;
        we_d         = we_q;
        offset_d     = offset_q;
        funct3_d     = funct3_q;
        misaligned_d = 1'b0;

        if (ack_busy) begin
            state_d = ST_IDLE;
        end

        // With back-to-back enabled this can fire in the ack cycle and
        // overrides the return to IDLE for a legal request.
        if (accept) begin
            if (req_illegal) begin
                misaligned_d = 1'b1;
            end else begin
                state_d     = ST_BUSY;
                dmem_en_d   = 1'b1;
                dmem_we_d   = req_we ? sa_be : 4'b0000;
                dmem_addr_d = req_addr[DMEM_AW+1:2];
                we_d        = req_we;
                offset_d    = req_addr[1:0];
                funct3_d    = req_funct3;
                if (req_we) begin
                    dmem_din_d = sa_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dmem_en_q    <= 1'b0;
            dmem_we_q    <= 4'b0000;
            dmem_addr_q  <= '0;
            dmem_din_q   <= 32'd0;
            we_q         <= 1'b0;
            offset_q     <= 2'd0;
            funct3_q     <= 3'd0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_en_q    <= dmem_en_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_din_q   <= dmem_din_d;
            we_q         <= we_d;
            offset_q     <= offset_d;
            funct3_q     <= funct3_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign dmem_en    = dmem_en_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_din   = dmem_din_q;
    assign lsm_offset = offset_q;
    assign lsm_width  = funct3_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_ama_riscv_dmem_req.sv
// tb_ama_riscv_dmem_req
// Directed self-checking bench for ama_riscv_dmem_req. Inputs change one
// time unit after the rising edge; outputs are checked a further time unit
// later, well before the next edge.
module tb_ama_riscv_dmem_req;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_din;
    logic        dmem_ack;
    logic        lsm_en;
    logic [1:0]  lsm_offset;
    logic [2:0]  lsm_width;
    logic        misaligned;
    logic        stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ama_riscv_dmem_req dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .dmem_en    (dmem_en),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_din   (dmem_din),
        .dmem_ack   (dmem_ack),
        .lsm_en     (lsm_en),
        .lsm_offset (lsm_offset),
        .lsm_width  (lsm_width),
        .misaligned (misaligned),
        .stall      (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns in the cycle after
    // the accepting edge with req_valid already dropped.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] wdata);
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        #1;
        chk("issue_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [0:9] stall_exp;
    int         b2b_cyc;
    logic       prev_en;
    int         en_count;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_funct3 = 3'd0; req_wdata = 32'd0; dmem_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        // Reset state
        chk("rst_dmem_en",    {31'd0, dmem_en}, 32'd0);
        chk("rst_dmem_we",    {28'd0, dmem_we}, 32'd0);
        chk("rst_dmem_addr",  {18'd0, dmem_addr}, 32'd0);
        chk("rst_dmem_din",   dmem_din, 32'd0);
        chk("rst_lsm_en",     {31'd0, lsm_en}, 32'd0);
        chk("rst_lsm_offset", {30'd0, lsm_offset}, 32'd0);
        chk("rst_lsm_width",  {29'd0, lsm_width}, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        chk("rst_req_ready",  {31'd0, req_ready}, 32'd1);

        // Load word at 0x10, ack 3 cycles after dmem_en
        issue(1'b0, 32'h0000_0010, 3'b010, 32'd0);
        chk("lw_en",      {31'd0, dmem_en}, 32'd1);
        chk("lw_addr",    {18'd0, dmem_addr}, 32'd4);
        chk("lw_we",      {28'd0, dmem_we}, 32'd0);
        chk("lw_lsm_en0", {31'd0, lsm_en}, 32'd0);
        chk("lw_ready0",  {31'd0, req_ready}, 32'd0);
        tick(); #1;
        chk("lw_en_pulse", {31'd0, dmem_en}, 32'd0);
        chk("lw_lsm_en1",  {31'd0, lsm_en}, 32'd0);
        tick(); #1;
        chk("lw_lsm_en2",  {31'd0, lsm_en}, 32'd0);
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("lw_lsm_en_ack", {31'd0, lsm_en}, 32'd1);
        chk("lw_lsm_offset", {30'd0, lsm_offset}, 32'd0);
        chk("lw_lsm_width",  {29'd0, lsm_width}, 32'd2);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("lw_lsm_en_after", {31'd0, lsm_en}, 32'd0);
        chk("lw_ready_after",  {31'd0, req_ready}, 32'd1);

        // Store byte at 0x7
        issue(1'b1, 32'h0000_0007, 3'b000, 32'hDEAD_BEA5);
        chk("sb_en",   {31'd0, dmem_en}, 32'd1);
        chk("sb_we",   {28'd0, dmem_we}, 32'h8);
        chk("sb_din",  dmem_din, 32'hA5A5_A5A5);
        chk("sb_addr", {18'd0, dmem_addr}, 32'd1);
        chk("sb_lsm0", {31'd0, lsm_en}, 32'd0);
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("sb_lsm_ack", {31'd0, lsm_en}, 32'd0);
        tick();
        dmem_ack = 1'b0;

        // Store half at 0x2
        issue(1'b1, 32'h0000_0002, 3'b001, 32'h1234_5678);
        chk("sh_we",  {28'd0, dmem_we}, 32'hC);
        chk("sh_din", dmem_din, 32'h5678_5678);
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("sh_lsm_ack", {31'd0, lsm_en}, 32'd0);
        tick();
        dmem_ack = 1'b0;

        // Store word at 0x20
        issue(1'b1, 32'h0000_0020, 3'b010, 32'hCAFE_F00D);
        chk("sw_we",   {28'd0, dmem_we}, 32'hF);
        chk("sw_din",  dmem_din, 32'hCAFE_F00D);
        chk("sw_addr", {18'd0, dmem_addr}, 32'd8);
        tick();
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;

        // Misaligned: lh @3 then lw @1 back to back, both rejected
        issue(1'b0, 32'h0000_0003, 3'b001, 32'd0);
        chk("mis_lh_pulse", {31'd0, misaligned}, 32'd1);
        chk("mis_lh_en",    {31'd0, dmem_en}, 32'd0);
        issue(1'b0, 32'h0000_0001, 3'b010, 32'd0);
        chk("mis_lw_pulse", {31'd0, misaligned}, 32'd1);
        chk("mis_lw_en",    {31'd0, dmem_en}, 32'd0);
        chk("mis_lw_ready", {31'd0, req_ready}, 32'd1);
        // Store carrying the unsigned flag
        issue(1'b1, 32'h0000_0000, 3'b100, 32'd0);
        chk("mis_sbu_pulse", {31'd0, misaligned}, 32'd1);
        chk("mis_sbu_en",    {31'd0, dmem_en}, 32'd0);
        // Reserved size 3
        issue(1'b0, 32'h0000_0000, 3'b011, 32'd0);
        chk("mis_sz3_pulse", {31'd0, misaligned}, 32'd1);
        tick(); #1;
        chk("mis_clear", {31'd0, misaligned}, 32'd0);
        chk("mis_no_en", {31'd0, dmem_en}, 32'd0);

        // lbu at offset 3 is legal
        issue(1'b0, 32'h0000_0103, 3'b100, 32'd0);
        chk("lbu_en",   {31'd0, dmem_en}, 32'd1);
        chk("lbu_addr", {18'd0, dmem_addr}, 32'h40);
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("lbu_lsm_en",     {31'd0, lsm_en}, 32'd1);
        chk("lbu_lsm_offset", {30'd0, lsm_offset}, 32'd3);
        chk("lbu_lsm_width",  {29'd0, lsm_width}, 32'd4);
        tick();
        dmem_ack = 1'b0;

        // Back-to-back loads, ack one cycle after each dmem_en
`ifdef DMEM_REQ_B2B_EN
        stall_exp = 10'b0101010000;
        b2b_cyc   = 7;
`else
        stall_exp = 10'b0110110110;
        b2b_cyc   = 10;
`endif
        prev_en    = 1'b0;
        en_count   = 0;
        req_we     = 1'b0;
        req_addr   = 32'h0000_0044;
        req_funct3 = 3'b010;
        req_valid  = 1'b1;
        for (int c = 0; c < b2b_cyc; c++) begin
            dmem_ack = prev_en;
            #1;
            chk($sformatf("b2b_stall_c%0d", c), {31'd0, stall}, {31'd0, stall_exp[c]});
            chk($sformatf("b2b_lsm_c%0d", c), {31'd0, lsm_en}, {31'd0, prev_en});
            if (dmem_en) en_count++;
            prev_en = dmem_en;
            tick();
        end
        req_valid = 1'b0;
        dmem_ack  = prev_en;
        #1;
        chk("b2b_last_en", {31'd0, dmem_en}, 32'd1);
        en_count++;
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("b2b_last_lsm", {31'd0, lsm_en}, 32'd1);
        chk("b2b_en_count", en_count, 32'd4);
        tick();
        dmem_ack = 1'b0;

        // Reset while BUSY, ack coincident with and after reset
        issue(1'b0, 32'h0000_0008, 3'b010, 32'd0);
        chk("rb_en", {31'd0, dmem_en}, 32'd1);
        rst      = 1'b1;
        dmem_ack = 1'b1;
        #1;
        chk("rb_lsm_during_rst", {31'd0, lsm_en}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rb_lsm_after",    {31'd0, lsm_en}, 32'd0);
        chk("rb_ready",        {31'd0, req_ready}, 32'd1);
        chk("rb_dmem_en",      {31'd0, dmem_en}, 32'd0);
        chk("rb_dmem_addr",    {18'd0, dmem_addr}, 32'd0);
        chk("rb_lsm_width",    {29'd0, lsm_width}, 32'd0);
        chk("rb_misaligned",   {31'd0, misaligned}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        issue(1'b0, 32'h0000_000C, 3'b001, 32'd0);
        chk("rb_next_en",   {31'd0, dmem_en}, 32'd1);
        chk("rb_next_addr", {18'd0, dmem_addr}, 32'd3);
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("rb_next_lsm",   {31'd0, lsm_en}, 32'd1);
        chk("rb_next_width", {29'd0, lsm_width}, 32'd1);
        tick();
        dmem_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ama_riscv_dmem_req.md
# ama_riscv_dmem_req

Data-memory request stage of the AMA-RISCV load/store path. It accepts one load or store per handshake, checks alignment, and drives the data memory with word address, byte-enables and lane-replicated store data. It waits for the memory acknowledge. On a load acknowledge it drives `en`/`offset`/`width` to the downstream `ama_riscv_load_shift_mask`, aligned with the returning `dmem_dout` that feeds that block's `data_in`.

## Interface
- `DMEM_AW`, 14: word-address width of the data memory.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_funct3`  in  3  RISC-V funct3: [1:0] size (0 byte, 1 half, 2 word); [2] unsigned-load flag.
- `req_wdata`  in  32  store data, LSB-justified.
- `dmem_en`  out  1  memory access strobe, one-cycle pulse.
- `dmem_we`  out  4  byte write-enables; 0 for loads.
- `dmem_addr`  out  DMEM_AW  `req_addr[DMEM_AW+1:2]`.
- `dmem_din`  out  32  store data replicated to all lanes.
- `dmem_ack`  in  1  memory done; `dmem_dout` valid in the same cycle.
- `lsm_en`  out  1  to load_shift_mask `en`.
- `lsm_offset`  out  2  to load_shift_mask `offset`.
- `lsm_width`  out  3  to load_shift_mask `width` (= funct3).
- `misaligned`  out  1  one-cycle pulse for a rejected request.
- `stall`  out  1  `req_valid && !req_ready`.

## Operation
- FSM states: IDLE, BUSY. Reset → IDLE.
- IDLE: `req_ready=1`.
- Accept, legal request → register op/offset/funct3 and pulse `dmem_*` next cycle → BUSY.
- Accept, illegal request → `misaligned` pulse next cycle, no dmem access, stay IDLE.
- Illegal cases: size 3; half with offset 3; word with offset ≠ 0; store with funct3[2]=1.
- BUSY: `req_ready=0`. Waits for `dmem_ack`; on ack → IDLE.
- Store byte-enables: byte `4'b0001<<off`; half `4'b0011<<off` (off 0–2); word `4'b1111`.
- Store data: byte `{4{wdata[7:0]}}`; half `{2{wdata[15:0]}}`; word `wdata`.
- `lsm_en = BUSY && dmem_ack && !we_q` (combinational). `lsm_offset`/`lsm_width` are the held registers, stable throughout BUSY.
- `dmem_ack` in IDLE is ignored.

## Timing
- Reset values: `dmem_en=0`, `dmem_we=0`, `dmem_addr=0`, `dmem_din=0`, `lsm_en=0`, `lsm_offset=0`, `lsm_width=0`, `misaligned=0`. `req_ready=1` in the first cycle after reset.
- Accept at edge N → `dmem_en` high during cycle N+1 only. Earliest legal `dmem_ack` is cycle N+2. Ack latency is unbounded.
- Load result: load_shift_mask registers on the edge ending the ack cycle → `data_out` valid one cycle after ack.
- Minimum occupancy: 2 cycles per access (3 without `DMEM_REQ_B2B_EN`, counting the IDLE re-accept).
- Misaligned: accept at N → `misaligned` high in cycle N+1; `req_ready` stays 1.
- `rst` mid-BUSY → IDLE next edge. The pending ack is dropped and `lsm_en` is not asserted.
- `dmem_ack` coincident with `rst` is ignored.

## Configuration
- `DMEM_REQ_B2B_EN` defined: `req_ready = IDLE || (BUSY && dmem_ack)`. A new request accepted in the ack cycle issues `dmem_en` the next cycle, giving one access per 2 cycles.
- Undefined: `req_ready` only in IDLE, so there is one idle cycle between accesses.

## Structure
- Shared package `ama_riscv_lsu_pkg`:
  - size encodings `SZ_B=2'd0`, `SZ_H=2'd1`, `SZ_W=2'd2`;
  - FSM state encoding;
  - `FUNCT3_UNSIGNED_BIT=2`.
- One combinational sub-module `ama_riscv_store_align`: (size, offset, wdata) → (byte-enable, lane data, illegal). It is reused for the misalignment check.

## Test plan
- Load word: addr `0x0000_0010`, funct3 `3'b010`, ack 3 cycles after `dmem_en`.
  → `dmem_addr=4`, `dmem_we=0`; `lsm_en` high only in the ack cycle with offset 0, width `3'b010`.
- Store byte: addr `0x0000_0007`, funct3 `3'b000`, wdata `0xDEAD_BEA5`.
  → `dmem_we=4'b1000`, `dmem_din=0xA5A5_A5A5`, `dmem_addr=1`; `lsm_en` never high.
- Store half: addr `0x0000_0002`, wdata `0x1234_5678`.
  → `dmem_we=4'b1100`, `dmem_din=0x5678_5678`.
- Misaligned: lh at addr `0x0000_0003`, then lw at `0x0000_0001`.
  → two `misaligned` pulses, no `dmem_en`, `req_ready` stays 1.
- Back-to-back: `req_valid` held for 4 loads with ack always 1 cycle after `dmem_en`.
  → `stall` high on alternate cycles with `DMEM_REQ_B2B_EN`; 2 of 3 cycles without it.
- Reset in BUSY, then `dmem_ack`.
  → `lsm_en=0`, all outputs at reset values, the next request is accepted normally.
